// File: rtl/riscv_pkg.sv
// Shared RV32 constants: opcodes, next-PC select encodings, the canonical NOP
// and the instruction-fetch FSM state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JAL  = 2'b10;
  localparam logic [1:0] PC_JALR = 2'b11;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } ifetch_state_t;

endpackage

// File: rtl/npc_gen.sv
// Combinational next-PC selection for the fetch unit, with an alignment flag
// for targets that are not on a 4-byte boundary.
module npc_gen
  import riscv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_sel,
  input  logic        branch,
  input  logic        br_taken,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic [31:0] npc,
  output logic        misaligned
);

  logic [31:0] seq_pc;
  logic [31:0] rel_pc;

  assign seq_pc = pc + 32'd4;
  assign rel_pc = pc + imm;

  always_comb begin
    npc = seq_pc;
    case (pc_sel)
      PC_SEQ:  npc = seq_pc;
      PC_BR:   npc = (branch && br_taken) ? rel_pc : seq_pc;
      PC_JAL:  npc = rel_pc;
      PC_JALR: npc = {alu_result[31:1], 1'b0};
      default: npc = seq_pc;
    endcase
  end

  assign misaligned = |npc[1:0];

endmodule

// File: rtl/ifetch.sv
// Multi-cycle instruction fetch unit: FETCH waits on imem, EXEC presents the
// instruction and advances the PC, HALT freezes after any fetch error.
module ifetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  pc_sel_i,
  input  logic        branch_i,
  input  logic        br_taken_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] alu_result_i,
  input  logic        hold_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic        fetch_err_o,
  output logic [31:0] retired_o,
  output logic [1:0]  state_o
);

  localparam int WW = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TMO_LAST = WW'(IMEM_TIMEOUT - 1);

  ifetch_state_t state, state_d;
  logic [31:0]   pc, pc_d;
  logic [31:0]   inst, inst_d;
  logic [31:0]   retired, retired_d;
  logic          err, err_d;
  logic [WW-1:0] wait_cnt, wait_d;
  logic [31:0]   npc;
  logic          misaligned;

  npc_gen u_npc_gen (
    .pc         (pc),
    .pc_sel     (pc_sel_i),
    .branch     (branch_i),
    .br_taken   (br_taken_i),
    .imm        (imm_i),
    .alu_result (alu_result_i),
    .npc        (npc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      inst     <= NOP;
      retired  <= 32'd0;
      err      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      inst     <= inst_d;
      retired  <= retired_d;
      err      <= err_d;
      wait_cnt <= wait_d;
    end
  end

  // Controller inputs only matter in EXEC; imem_ready_i only matters in FETCH.
  always_comb begin
    state_d   = state;
    pc_d      = pc;
    inst_d    = inst;
    retired_d = retired;
    err_d     = err;
    wait_d    = wait_cnt;
    case (state)
      ST_FETCH: begin
        if (imem_ready_i) begin
          inst_d  = imem_rdata_i;
          wait_d  = '0;
          state_d = ST_EXEC;
        end else if (wait_cnt == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          wait_d = wait_cnt + WW'(1);
        end
      end
      ST_EXEC: begin
        if (!hold_i) begin
          retired_d = retired + 32'd1;
          if (misaligned) begin
            // The faulting instruction still retires; pc stays on it.
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d    = npc;
            state_d = ST_FETCH;
          end
        end
      end
      default: ;
    endcase
  end

  // State resets to FETCH, so the request is masked while reset is held.
  assign imem_req_o   = rst_n_i && (state == ST_FETCH);
  assign imem_addr_o  = pc;
  assign inst_valid_o = (state == ST_EXEC);
  assign inst_o       = inst;
  assign pc_o         = pc;
  assign pc4_o        = pc + 32'd4;
  assign fetch_err_o  = err;
  assign retired_o    = retired;
  assign state_o      = state;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: sequential flow, branches/jumps, hold, imem wait
// states, async reset mid-fetch, misaligned jalr and imem timeout.
module tb_ifetch;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pc_sel;
  logic        branch;
  logic        br_taken;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        hold;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic        fetch_err_o;
  logic [31:0] retired_o;
  logic [1:0]  state_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc = 32'd0;
  logic [31:0] exp_ret = 32'd0;

  ifetch #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(16)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .pc_sel_i     (pc_sel),
    .branch_i     (branch),
    .br_taken_i   (br_taken),
    .imm_i        (imm),
    .alu_result_i (alu_result),
    .hold_i       (hold),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ready_i (imem_ready),
    .imem_rdata_i (imem_rdata),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .pc_o         (pc_o),
    .pc4_o        (pc4_o),
    .fetch_err_o  (fetch_err_o),
    .retired_o    (retired_o),
    .state_o      (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Answer the current FETCH immediately; returns in EXEC.
  task automatic fetch_cycle();
    imem_ready = 1'b1;
    imem_rdata = mem_word(exp_pc);
    step();
    imem_ready = 1'b0;
  endtask

  // Retire the instruction in EXEC with the given controller inputs.
  task automatic exec_cycle(input logic [1:0] sel, input logic br, input logic tk,
                            input logic [31:0] im, input logic [31:0] alu);
    pc_sel = sel; branch = br; br_taken = tk; imm = im; alu_result = alu;
    hold = 1'b0;
    step();
    exp_ret = exp_ret + 32'd1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    pc_sel = PC_SEQ; branch = 1'b0; br_taken = 1'b0; imm = 32'd0;
    alu_result = 32'd0; hold = 1'b0;
    step(); step(); #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", inst_valid_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 00000000", pc_o); end
    checks++; if (pc4_o !== 32'h4) begin errors++; $display("FAIL rst_pc4: got %h expected 00000004", pc4_o); end
    checks++; if (inst_o !== 32'h0000_0013) begin errors++; $display("FAIL rst_inst: got %h expected 00000013", inst_o); end
    checks++; if (retired_o !== 32'd0) begin errors++; $display("FAIL rst_retired: got %0d expected 0", retired_o); end
    checks++; if (fetch_err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", fetch_err_o); end
    @(negedge clk);
    rst_n = 1'b1; imem_ready = 1'b0;
    exp_pc = 32'd0; exp_ret = 32'd0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      pc_sel = PC_SEQ; hold = 1'b0; imem_ready = 1'b1; imem_rdata = mem_word(exp_pc);
      #1;
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc) begin errors++; $display("FAIL seq_fetch: got req=%b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, exp_pc); end
      checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL seq_fetch_valid: got %b expected 0", inst_valid_o); end
      step(); #1;
      checks++; if (inst_valid_o !== 1'b1 || imem_req_o !== 1'b0) begin errors++; $display("FAIL seq_exec: got valid=%b req=%b expected valid=1 req=0", inst_valid_o, imem_req_o); end
      checks++; if (inst_o !== mem_word(exp_pc)) begin errors++; $display("FAIL seq_inst: got %h expected %h", inst_o, mem_word(exp_pc)); end
      checks++; if (pc_o !== exp_pc || pc4_o !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_pc: got pc=%h pc4=%h expected pc=%h pc4=%h", pc_o, pc4_o, exp_pc, exp_pc + 32'd4); end
      imem_ready = 1'b0;
      step();
      exp_pc = exp_pc + 32'd4; exp_ret = exp_ret + 32'd1;
    end
    #1;
    checks++; if (retired_o !== 32'd3) begin errors++; $display("FAIL seq_retired: got %0d expected 3", retired_o); end
    checks++; if (imem_addr_o !== 32'hC) begin errors++; $display("FAIL seq_addr3: got %h expected 0000000c", imem_addr_o); end
  endtask

  task automatic test_branch();
    fetch_cycle(); exec_cycle(PC_JAL, 1'b0, 1'b0, 32'h0000_00F4, 32'h0); exp_pc = 32'h100; #1;
    checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL jal_target: got %h expected 00000100", imem_addr_o); end
    fetch_cycle(); exec_cycle(PC_BR, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0); exp_pc = 32'hF0; #1;
    checks++; if (imem_addr_o !== 32'hF0) begin errors++; $display("FAIL br_taken: got %h expected 000000f0", imem_addr_o); end
    fetch_cycle(); exec_cycle(PC_JAL, 1'b0, 1'b0, 32'h0000_0010, 32'h0); exp_pc = 32'h100; #1;
    checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL jal_fwd: got %h expected 00000100", imem_addr_o); end
    fetch_cycle(); exec_cycle(PC_BR, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0); exp_pc = 32'h104; #1;
    checks++; if (imem_addr_o !== 32'h104) begin errors++; $display("FAIL br_not_taken: got %h expected 00000104", imem_addr_o); end
    fetch_cycle(); exec_cycle(PC_BR, 1'b0, 1'b1, 32'h0000_0040, 32'h0); exp_pc = 32'h108; #1;
    checks++; if (imem_addr_o !== 32'h108) begin errors++; $display("FAIL br_not_branch: got %h expected 00000108", imem_addr_o); end
    fetch_cycle(); exec_cycle(PC_JALR, 1'b0, 1'b0, 32'h0, 32'h0000_2001); exp_pc = 32'h2000; #1;
    checks++; if (imem_addr_o !== 32'h2000 || fetch_err_o !== 1'b0) begin errors++; $display("FAIL jalr_aligned: got addr=%h err=%b expected addr=00002000 err=0", imem_addr_o, fetch_err_o); end
    checks++; if (retired_o !== exp_ret) begin errors++; $display("FAIL br_retired: got %0d expected %0d", retired_o, exp_ret); end
  endtask

  task automatic test_hold();
    fetch_cycle();
    hold = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    pc_sel = PC_JAL; imm = 32'h40;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (inst_o !== mem_word(32'h2000) || pc_o !== 32'h2000) begin errors++; $display("FAIL hold_stable: got inst=%h pc=%h expected inst=%h pc=00002000", inst_o, pc_o, mem_word(32'h2000)); end
      checks++; if (retired_o !== exp_ret || imem_req_o !== 1'b0 || inst_valid_o !== 1'b1) begin errors++; $display("FAIL hold_ctrl: got ret=%0d req=%b valid=%b expected ret=%0d req=0 valid=1", retired_o, imem_req_o, inst_valid_o, exp_ret); end
      step();
    end
    hold = 1'b0; imem_ready = 1'b0; pc_sel = PC_SEQ;
    step(); exp_ret = exp_ret + 32'd1; exp_pc = 32'h2004; #1;
    checks++; if (retired_o !== exp_ret || imem_addr_o !== exp_pc) begin errors++; $display("FAIL hold_release: got ret=%0d addr=%h expected ret=%0d addr=%h", retired_o, imem_addr_o, exp_ret, exp_pc); end
  endtask

  task automatic test_wait();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc) begin errors++; $display("FAIL wait_req: got req=%b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, exp_pc); end
      step();
    end
    imem_ready = 1'b1; imem_rdata = mem_word(exp_pc); #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc) begin errors++; $display("FAIL wait_req4: got req=%b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, exp_pc); end
    step(); imem_ready = 1'b0; #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== mem_word(exp_pc)) begin errors++; $display("FAIL wait_inst: got valid=%b inst=%h expected valid=1 inst=%h", inst_valid_o, inst_o, mem_word(exp_pc)); end
    exec_cycle(PC_JAL, 1'b0, 1'b0, 32'hFFFF_E03C, 32'h0); exp_pc = 32'h40;
  endtask

  task automatic test_reset_mid_fetch();
    imem_ready = 1'b0; #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin errors++; $display("FAIL mid_pre: got req=%b addr=%h expected req=1 addr=00000040", imem_req_o, imem_addr_o); end
    step(); #2;
    rst_n = 1'b0; #1;
    checks++; if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || pc_o !== 32'h0) begin errors++; $display("FAIL mid_rst_ctrl: got req=%b valid=%b pc=%h expected req=0 valid=0 pc=00000000", imem_req_o, inst_valid_o, pc_o); end
    checks++; if (inst_o !== 32'h0000_0013 || retired_o !== 32'd0 || fetch_err_o !== 1'b0) begin errors++; $display("FAIL mid_rst_regs: got inst=%h ret=%0d err=%b expected inst=00000013 ret=0 err=0", inst_o, retired_o, fetch_err_o); end
    checks++; if (state_o !== ST_FETCH) begin errors++; $display("FAIL mid_rst_state: got %0d expected %0d", state_o, ST_FETCH); end
    @(negedge clk);
    rst_n = 1'b1; exp_pc = 32'h0; exp_ret = 32'd0;
    imem_ready = 1'b1; imem_rdata = mem_word(32'h0); #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL mid_refetch: got req=%b addr=%h expected req=1 addr=00000000", imem_req_o, imem_addr_o); end
    step(); imem_ready = 1'b0; #1;
    checks++; if (inst_o !== mem_word(32'h0) || pc_o !== 32'h0 || inst_valid_o !== 1'b1) begin errors++; $display("FAIL mid_late_ready: got inst=%h pc=%h valid=%b expected inst=%h pc=00000000 valid=1", inst_o, pc_o, inst_valid_o, mem_word(32'h0)); end
  endtask

  task automatic test_jalr_misaligned();
    exec_cycle(PC_JALR, 1'b0, 1'b0, 32'h0, 32'h0000_2003); #1;
    checks++; if (fetch_err_o !== 1'b1 || state_o !== ST_HALT) begin errors++; $display("FAIL jalr_err: got err=%b state=%0d expected err=1 state=%0d", fetch_err_o, state_o, ST_HALT); end
    checks++; if (pc_o !== 32'h0 || retired_o !== exp_ret) begin errors++; $display("FAIL jalr_pc: got pc=%h ret=%0d expected pc=00000000 ret=%0d", pc_o, retired_o, exp_ret); end
    imem_ready = 1'b1; pc_sel = PC_JAL; imm = 32'h100;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || pc_o !== 32'h0 || retired_o !== exp_ret || fetch_err_o !== 1'b1) begin errors++; $display("FAIL halt_frozen: got req=%b valid=%b pc=%h ret=%0d err=%b expected req=0 valid=0 pc=00000000 ret=%0d err=1", imem_req_o, inst_valid_o, pc_o, retired_o, fetch_err_o, exp_ret); end
      step();
    end
    imem_ready = 1'b0;
  endtask

  task automatic test_timeout();
    rst_n = 1'b0; step(); rst_n = 1'b1; imem_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++; if (imem_req_o !== 1'b1 || fetch_err_o !== 1'b0) begin errors++; $display("FAIL tmo_wait%0d: got req=%b err=%b expected req=1 err=0", k, imem_req_o, fetch_err_o); end
      step();
    end
    #1;
    checks++; if (fetch_err_o !== 1'b1 || imem_req_o !== 1'b0 || state_o !== ST_HALT) begin errors++; $display("FAIL tmo_err: got err=%b req=%b state=%0d expected err=1 req=0 state=%0d", fetch_err_o, imem_req_o, state_o, ST_HALT); end
    imem_ready = 1'b1; step(); #1;
    checks++; if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== 32'h0000_0013) begin errors++; $display("FAIL tmo_frozen: got req=%b valid=%b inst=%h expected req=0 valid=0 inst=00000013", imem_req_o, inst_valid_o, inst_o); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_hold();
    test_wait();
    test_reset_mid_fetch();
    test_jalr_misaligned();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter IMEM_TIMEOUT, default 16, max FETCH cycles waiting for imem_ready_i before error.
REQ-003 clk_i  input  1  single clock, all state on rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 pc_sel_i  input  2  npc select from controller: 00 seq, 01 branch, 10 jal, 11 jalr.
REQ-006 branch_i  input  1  B-type instruction in execution.
REQ-007 br_taken_i  input  1  ALU compare result for current B-type instruction.
REQ-008 imm_i  input  32  sign-extended immediate of current instruction.
REQ-009 alu_result_i  input  32  rs1+imm for jalr.
REQ-010 hold_i  input  1  downstream stall; keeps current instruction presented.
REQ-011 imem_req_o  output  1  instruction memory request.
REQ-012 imem_addr_o  output  32  instruction memory address.
REQ-013 imem_ready_i  input  1  imem_rdata_i valid this cycle.
REQ-014 imem_rdata_i  input  32  instruction word.
REQ-015 inst_o  output  32  registered instruction to decoder/controller.
REQ-016 inst_valid_o  output  1  inst_o is executing this cycle.
REQ-017 pc_o  output  32  PC of inst_o.
REQ-018 pc4_o  output  32  pc_o+4, link value for jal/jalr write-back.
REQ-019 fetch_err_o  output  1  sticky: misaligned target or imem timeout.
REQ-020 retired_o  output  32  count of retired instructions.

Function
REQ-021 FSM states SHALL be FETCH, EXEC, HALT.
REQ-022 FETCH: imem_req_o=1, imem_addr_o=pc; on imem_ready_i=1 inst register <= imem_rdata_i, wait counter cleared, next state EXEC.
REQ-023 FETCH without imem_ready_i SHALL increment the wait counter; when it reaches IMEM_TIMEOUT-1 without ready, fetch_err_o<=1, next state HALT.
REQ-024 EXEC: inst_valid_o=1, imem_req_o=0; hold_i=1 keeps EXEC with pc, inst_o unchanged.
REQ-025 EXEC with hold_i=0: pc<=npc, retired_o<=retired_o+1 (wraps 32'hFFFF_FFFF->0), next state FETCH, unless npc misaligned.
REQ-026 npc: 00 -> pc+4; 01 -> pc+imm_i if branch_i&br_taken_i else pc+4; 10 -> pc+imm_i; 11 -> {alu_result_i[31:1],1'b0}; all sums modulo 2^32.
REQ-027 npc[1]=1 (npc[1:0]!=00 after jalr bit-0 clear) SHALL set fetch_err_o, leave pc unchanged, still count the instruction retired, next state HALT.
REQ-028 HALT: imem_req_o=0, inst_valid_o=0, all state frozen until reset.
REQ-029 Min latency: 2 cycles per instruction (ready in first FETCH cycle, then EXEC).
REQ-030 pc4_o SHALL equal pc_o+4 combinationally in every state.
REQ-031 pc_sel_i, branch_i, br_taken_i, imm_i, alu_result_i SHALL be sampled only in EXEC; ignored in FETCH/HALT.
REQ-032 imem_ready_i outside FETCH SHALL be ignored.

Reset
REQ-033 rst_n_i=0 SHALL immediately force state FETCH, pc=RESET_PC, inst_o=32'h0000_0013 (nop), retired_o=0, fetch_err_o=0, wait counter=0.
REQ-034 During reset imem_req_o=0 and inst_valid_o=0; first request asserted in first cycle after rst_n_i rises.
REQ-035 Reset asserted mid-FETCH or mid-EXEC SHALL abandon the transaction; a late imem_ready_i after reset release is treated as response to the new RESET_PC fetch.

Structure
REQ-036 Shared package riscv_pkg SHALL hold opcode constants, pc_sel encodings (PC_SEQ, PC_BR, PC_JAL, PC_JALR), NOP constant, ifetch state encoding.
REQ-037 Combinational next-PC logic SHALL be a sub-module npc_gen (inputs pc, pc_sel, branch, br_taken, imm, alu_result; outputs npc, misaligned).

Verification
REQ-038 Reset release, imem always ready, pc_sel=00 -> addresses 0,4,8 on imem_addr_o in cycles 1,3,5; retired_o=3 after cycle 6.
REQ-039 pc=0x100, pc_sel=01, branch_i=1, br_taken_i=1, imm=0xFFFF_FFF0 -> next fetch 0x0F0; same with br_taken_i=0 -> 0x104.
REQ-040 pc_sel=11, alu_result_i=0x0000_2003 -> next fetch 0x2002 rejected: fetch_err_o=1, HALT, pc_o stays, imem_req_o=0 thereafter.
REQ-041 imem_ready_i delayed 3 cycles -> imem_req_o held 4 cycles, address stable; never ready for 16 cycles -> fetch_err_o=1, HALT.
REQ-042 hold_i=1 for 5 EXEC cycles -> inst_o, pc_o stable, retired_o unchanged, no imem_req_o; release -> single increment.
REQ-043 rst_n_i pulsed low mid-FETCH at pc=0x40 -> outputs return to reset values asynchronously; next request address RESET_PC.
